sipo: RTL
=========

# sipo

Serial-in, parallel-out buffer: accepts one bit per cycle on a valid/ready serial port and assembles `DATA_BITS` bits, LSB first, into a word. It presents each word on a valid/ready parallel port. It is the receive-side counterpart of the parallel-in, serial-out register, and bit order matches it: the first serial bit becomes `output_data[0]`. The block is double-buffered, so a new word can shift in while the previous word waits for the consumer.

## Interface

- `DATA_BITS`, default 8, word width in bits; must be ≥ 2.
- `clk`, input, 1, clock; all state updates on the rising edge.
- `rst`, input, 1, reset; asynchronous, active-high.
- `input_valid`, input, 1, `input_bit` holds a valid bit.
- `input_bit`, input, 1, serial data bit.
- `input_ready`, output, 1, block can accept a bit this cycle.
- `output_valid`, output, 1, `output_data` holds a complete word.
- `output_data`, output, `DATA_BITS`, assembled word.
- `output_ready`, input, 1, consumer accepts the word this cycle.

## Operation

- State:
  - `shift[DATA_BITS-1:0]`, the assembly register.
  - `count`, 0..`DATA_BITS`, the bits held in `shift`; width is `$clog2(DATA_BITS+1)`.
  - `hold[DATA_BITS-1:0]`, the output register, drives `output_data`.
  - `hold_valid`, drives `output_valid`.
- Bit accept happens when `input_valid & input_ready`:
  - `shift <= {input_bit, shift[DATA_BITS-1:1]}` (enters at the MSB, shifts right).
  - `count <= count + 1`.
  - After `DATA_BITS` accepts, the first bit sits in `shift[0]`.
- `input_ready = (count != DATA_BITS)`.
  - It depends only on registered state, with no combinational path from `output_ready`.
  - The shift register is full only when a completed word could not move to `hold`.
- Output unload happens when `output_valid & output_ready`; it clears `hold_valid` unless a transfer occurs on the same edge.
- Transfer moves the assembled word from the shift register into `hold`.
  - Let `word_done = (count == DATA_BITS) | (count == DATA_BITS-1 & bit accept)`.
  - Let `hold_free = !hold_valid | unload`.
  - When `word_done & hold_free`:
    - `hold` gets the full word, including the bit accepted this cycle, if any.
    - `hold_valid <= 1`.
    - `count <= 0`.
  - When `word_done & !hold_free`: `count` saturates at `DATA_BITS`, `shift` is held and `input_ready` drops.
- Simultaneous events:
  - Unload and transfer on the same edge: `hold` is replaced, `output_valid` stays 1, and no bubble occurs.
  - Bit accept and unload on the same edge: both take effect independently.
- Stability: while `output_valid & !output_ready`, `output_data` must not change.
- Reset (asynchronous, immediate on `rst` rising):
  - `shift = 0`, `count = 0`, `hold = 0`, `hold_valid = 0`.
  - Resulting outputs: `output_valid = 0`, `output_data = 0`, `input_ready = 1`.
  - No bit is accepted while `rst` is high.
  - A partial word or a pending output word is discarded.
- There is no flush of partial words; a partial word remains in `shift` indefinitely.

## Timing

- Latency: the last bit of a word is accepted at edge N, and `output_valid = 1` with the word after edge N, provided `hold_free` at edge N.
- Throughput:
  - Sustains one bit per cycle indefinitely, provided the consumer unloads each word within `DATA_BITS` cycles of `output_valid` rising.
  - `input_ready` never drops in that regime.
- Backpressure:
  - With the consumer stalled, the block absorbs exactly 2×`DATA_BITS` bits.
  - Then `input_ready = 0` from the edge after the last accepted bit until the edge after the unload.
  - Recovery: the unload at edge M performs the transfer at M, and `input_ready = 1` after M.
- `input_valid` may toggle arbitrarily; idle cycles do not change state.

## Test plan

- **Reset values:** assert `rst` asynchronously mid-cycle, with no clock edge while it is high. Required: `output_valid` falls immediately, `output_data = 0`, `input_ready = 1`.
- **Single word (`DATA_BITS = 8`):** send bits 1,0,1,0,0,1,0,1 on consecutive cycles with `output_ready = 1`. Required: `output_data = 0xA5` and `output_valid = 1` exactly one cycle after the 8th accept; unloaded on the next edge.
- **Streaming:** send 64 continuous bits with `output_ready = 1`. Required:
  - `input_ready` stays 1 throughout.
  - 8 words are unloaded, matching the LSB-first packing.
  - `output_valid` pulses for one cycle every 8 cycles.
- **Backpressure:** hold `output_ready = 0` and send 0x3C then 0xC3 (16 bits). Required:
  - `output_data = 0x3C` stays stable.
  - `input_ready = 0` after the 16th accept, and the 17th bit is not accepted.
  - Raise `output_ready` for one cycle. Required: 0x3C is unloaded, `output_data = 0xC3` on the next cycle with `output_valid` still 1, and `input_ready = 1` again.
- **Gapped input and same-edge unload:** insert random `input_valid` gaps. Time the final bit of word 2 to arrive on the same edge as the unload of word 1. Required: no lost or duplicated word and no `output_valid` bubble.
- **Mid-word reset:** send 5 bits of a word, assert `rst`, then send a fresh 8-bit 0x5A. Required: exactly one word, 0x5A, is output; the 5 stale bits never appear.

Source files
------------

// File: rtl/sipo_if.sv
// sipo_if: serial-in and parallel-out valid/ready ports of the sipo block.
// master drives bits and consumes words; slave is the sipo itself.
interface sipo_if #(
  parameter int DATA_BITS = 8
);
  logic                 input_valid;
  logic                 input_bit;
  logic                 input_ready;
  logic                 output_valid;
  logic [DATA_BITS-1:0] output_data;
  logic                 output_ready;

  modport master (
    output input_valid,
    output input_bit,
    input  input_ready,
    input  output_valid,
    input  output_data,
    output output_ready
  );

  modport slave (
    input  input_valid,
    input  input_bit,
    output input_ready,
    output output_valid,
    output output_data,
    input  output_ready
  );
endinterface

// File: rtl/sipo.sv
// sipo: double-buffered serial-in/parallel-out, LSB first.
// A new word shifts in while the previous one waits in hold.
module sipo #(
  parameter int DATA_BITS = 8
) (
  input  logic   clk,
  input  logic   rst,
  sipo_if.slave  bus
);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nx;
  logic [DATA_BITS-1:0] hold;
  logic [CW-1:0]        count;
  logic                 hold_valid;
  logic                 accept;
  logic                 unload;
  logic                 word_done;
  logic                 hold_free;
  logic                 xfer;

  assign bus.input_ready  = (count != FULL);
  assign bus.output_valid = hold_valid;
  assign bus.output_data  = hold;

  assign accept = bus.input_valid & bus.input_ready;
  assign unload = hold_valid & bus.output_ready;

  always_comb begin
    shift_nx = shift;
    if (accept)
      shift_nx = {bus.input_bit, shift[DATA_BITS-1:1]};
  end

  // shift_nx carries this cycle's bit, so a word can land in hold directly
  assign word_done = (count == FULL)
                   | ((count == LAST) & accept);
  assign hold_free = ~hold_valid | unload;
  assign xfer      = word_done & hold_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else begin
      shift <= shift_nx;
      if (xfer)
        count <= '0;
      else if (accept)
        count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (xfer) begin
        hold       <= shift_nx;
        hold_valid <= 1'b1;
      end else if (unload) begin
        hold_valid <= 1'b0;
      end
    end
  end
endmodule
